// File: rtl/elastic_pipeline.sv
// elastic_pipeline
//   Chain of STAGES elastic register stages with a valid/ready handshake.
//   Each stage is a 2-entry skid buffer (main + skid). A stage's ready to
//   its upstream is the registered !skid_valid, so ready never depends
//   combinationally on downstream ready. One beat per cycle is sustained
//   under backpressure.
//
//   Optional feature: define PIPE_PARITY_EN to store an even-parity bit with
//   every entry and flag mismatches at the output. When it is undefined,
//   parity_err is tied low.
//
// Parameters
//   WIDTH      payload width (1..256)
//   STAGES     number of stages (1..8)
//   FLUSH_MASK bit i set -> stage i is cleared by flush (stage 0 = input side)
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     upstream handshake (in_ready registered)
//   in_data               upstream payload
//   out_valid/out_ready   downstream handshake
//   out_data              downstream payload
//   flush                 synchronous flush of the masked stages
//   occupancy             registered count of valid entries
//   parity_err            one-cycle pulse after a beat with bad parity fires
module elastic_pipeline #(
  parameter int unsigned       WIDTH      = 32,
  parameter int unsigned       STAGES     = 4,
  parameter logic [STAGES-1:0] FLUSH_MASK = {STAGES{1'b1}}
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [WIDTH-1:0]                in_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [WIDTH-1:0]                out_data,
  input  logic                            flush,
  output logic [$clog2(2*STAGES+1)-1:0]   occupancy,
  output logic                            parity_err
);

  localparam int unsigned OCC_W = $clog2(2*STAGES+1);

  logic [STAGES-1:0]             r_vm, r_vs, w_vm_nx, w_vs_nx;
  logic [STAGES-1:0][WIDTH-1:0]  r_dm, r_ds, w_dm_nx, w_ds_nx;
  logic [STAGES-1:0][WIDTH-1:0]  w_up_data;
  logic [STAGES-1:0]             w_up_valid, w_dn_ready, w_vout;
  logic [STAGES-1:0]             w_accept, w_fire, w_flush;
  logic [OCC_W-1:0]              r_occ, w_occ_nx;

`ifdef PIPE_PARITY_EN
  logic [STAGES-1:0]             r_pm, r_ps, w_pm_nx, w_ps_nx, w_up_par;
  logic                          r_perr;
`endif

  // Stage linkage: stage 0 faces in_*, the last stage faces out_*.
  assign w_up_valid[0]        = in_valid;
  assign w_up_data[0]         = in_data;
  assign w_dn_ready[STAGES-1] = out_ready;
`ifdef PIPE_PARITY_EN
  assign w_up_par[0]          = ^in_data;
`endif

  for (genvar g = 1; g < STAGES; g++) begin : g_link
    assign w_up_valid[g]   = w_vout[g-1];
    assign w_up_data[g]    = r_dm[g-1];
    assign w_dn_ready[g-1] = ~r_vs[g];
`ifdef PIPE_PARITY_EN
    assign w_up_par[g]     = r_pm[g-1];
`endif
  end

  assign w_flush  = {STAGES{flush}} & FLUSH_MASK;
  // A flushed stage presents nothing downstream during the flush cycle.
  assign w_vout   = r_vm & ~w_flush;
  assign w_accept = w_up_valid & ~r_vs;
  assign w_fire   = w_vout & w_dn_ready;

  always_comb begin
    w_vm_nx = r_vm;
    w_vs_nx = r_vs;
    w_dm_nx = r_dm;
    w_ds_nx = r_ds;
`ifdef PIPE_PARITY_EN
    w_pm_nx = r_pm;
    w_ps_nx = r_ps;
`endif
    for (int unsigned i = 0; i < STAGES; i++) begin
      if (w_flush[i]) begin
        // Upstream still sees its handshake complete; the beat is dropped.
        w_vm_nx[i] = 1'b0;
        w_vs_nx[i] = 1'b0;
`ifdef PIPE_PARITY_EN
        w_pm_nx[i] = 1'b0;
        w_ps_nx[i] = 1'b0;
`endif
      end else if (w_fire[i]) begin
        if (r_vs[i]) begin
          // accept cannot be high here since it requires an empty skid.
          w_dm_nx[i] = r_ds[i];
          w_vs_nx[i] = 1'b0;
`ifdef PIPE_PARITY_EN
          w_pm_nx[i] = r_ps[i];
`endif
        end else if (w_accept[i]) begin
          w_dm_nx[i] = w_up_data[i];
`ifdef PIPE_PARITY_EN
          w_pm_nx[i] = w_up_par[i];
`endif
        end else begin
          w_vm_nx[i] = 1'b0;
        end
      end else if (w_accept[i]) begin
        if (!r_vm[i]) begin
          w_vm_nx[i] = 1'b1;
          w_dm_nx[i] = w_up_data[i];
`ifdef PIPE_PARITY_EN
          w_pm_nx[i] = w_up_par[i];
`endif
        end else begin
          w_vs_nx[i] = 1'b1;
          w_ds_nx[i] = w_up_data[i];
`ifdef PIPE_PARITY_EN
          w_ps_nx[i] = w_up_par[i];
`endif
        end
      end
    end
  end

  // Count the next state so occupancy moves on the same edge as the entries.
  always_comb begin
    w_occ_nx = '0;
    for (int unsigned i = 0; i < STAGES; i++) begin
      w_occ_nx = w_occ_nx + OCC_W'(w_vm_nx[i]) + OCC_W'(w_vs_nx[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vm  <= '0;
      r_vs  <= '0;
      r_dm  <= '0;
      r_ds  <= '0;
      r_occ <= '0;
    end else begin
      r_vm  <= w_vm_nx;
      r_vs  <= w_vs_nx;
      r_dm  <= w_dm_nx;
      r_ds  <= w_ds_nx;
      r_occ <= w_occ_nx;
    end
  end

`ifdef PIPE_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pm   <= '0;
      r_ps   <= '0;
      r_perr <= 1'b0;
    end else begin
      r_pm   <= w_pm_nx;
      r_ps   <= w_ps_nx;
      r_perr <= w_fire[STAGES-1] & ((^r_dm[STAGES-1]) != r_pm[STAGES-1]);
    end
  end
  assign parity_err = r_perr;
`else
  assign parity_err = 1'b0;
`endif

  assign in_ready  = ~r_vs[0];
  assign out_valid = w_vout[STAGES-1];
  assign out_data  = r_dm[STAGES-1];
  assign occupancy = r_occ;

endmodule

// File: tb/tb_elastic_pipeline.sv
// Testbench for elastic_pipeline. Two instances share clock and reset:
// dut (full flush mask) and dut_m (FLUSH_MASK = 4'b0011). Expected beats
// come from a FIFO-queue reference: beats leave in acceptance order and the
// entry count equals accepted minus delivered.
module tb_elastic_pipeline;

  localparam int unsigned W  = 32;
  localparam int unsigned S  = 4;
  localparam int unsigned OW = $clog2(2*S+1);

  logic          clk = 1'b0;
  logic          rst_n;

  logic          in_valid, in_ready, out_valid, out_ready, flush, parity_err;
  logic [W-1:0]  in_data, out_data;
  logic [OW-1:0] occupancy;

  logic          m_in_valid, m_in_ready, m_out_valid, m_out_ready, m_flush, m_parity_err;
  logic [W-1:0]  m_in_data, m_out_data;
  logic [OW-1:0] m_occupancy;

  int unsigned   nvec = 0;
  int unsigned   nerr = 0;
  logic [W-1:0]  q[$];

  always #5 clk = ~clk;

  elastic_pipeline #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .flush(flush), .occupancy(occupancy), .parity_err(parity_err)
  );

  elastic_pipeline #(.WIDTH(W), .STAGES(S), .FLUSH_MASK(4'b0011)) dut_m (
    .clk(clk), .rst_n(rst_n),
    .in_valid(m_in_valid), .in_ready(m_in_ready), .in_data(m_in_data),
    .out_valid(m_out_valid), .out_ready(m_out_ready), .out_data(m_out_data),
    .flush(m_flush), .occupancy(m_occupancy), .parity_err(m_parity_err)
  );

  // Every task starts and ends 1 time unit after a rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    in_valid = 0; in_data = '0; out_ready = 0; flush = 0;
    m_in_valid = 0; m_in_data = '0; m_out_ready = 0; m_flush = 0;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    tick;
    q.delete();
  endtask

  task automatic test_reset;
    do_reset;
    nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    nvec++; if (out_data !== '0) begin nerr++; $display("FAIL reset_out_data: got %0h want 0", out_data); end
    nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    nvec++; if (occupancy !== '0) begin nerr++; $display("FAIL reset_occupancy: got %0d want 0", occupancy); end
    nvec++; if (parity_err !== 1'b0) begin nerr++; $display("FAIL reset_parity_err: got %b want 0", parity_err); end
    nvec++; if (m_in_ready !== 1'b1) begin nerr++; $display("FAIL reset_m_in_ready: got %b want 1", m_in_ready); end
  endtask

  // 16 back-to-back beats with out_ready=1: beat j accepted at edge j,
  // visible at the output after edge j+S-1.
  task automatic test_stream;
    logic         exp_v;
    logic [W-1:0] exp_d;
    do_reset;
    out_ready = 1;
    for (int unsigned k = 0; k < 16 + S + 2; k++) begin
      in_valid = (k < 16);
      in_data  = W'(k + 1);
      #1;
      if (k < 16) begin
        nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL stream_in_ready k=%0d: got %b want 1", k, in_ready); end
      end
      tick;
      exp_v = (k >= S - 1) && (k < 16 + S - 1);
      nvec++; if (out_valid !== exp_v) begin nerr++; $display("FAIL stream_out_valid k=%0d: got %b want %b", k, out_valid, exp_v); end
      if (exp_v) begin
        exp_d = W'(k - (S - 1) + 1);
        nvec++; if (out_data !== exp_d) begin nerr++; $display("FAIL stream_out_data k=%0d: got %0h want %0h", k, out_data, exp_d); end
      end
    end
    in_valid = 0;
  endtask

  task automatic test_backpressure;
    logic [W-1:0] nxt, exp_d;
    int unsigned  acc, delivered;
    logic         f, ov, rose;
    logic [W-1:0] od;
    do_reset;
    out_ready = 0; in_valid = 1; nxt = 32'h20; acc = 0;
    for (int unsigned c = 0; c < 20; c++) begin
      in_data = nxt;
      #1 f = in_ready;
      tick;
      if (f) begin q.push_back(nxt); nxt++; acc++; end
    end
    in_valid = 0;
    nvec++; if (acc !== 2*S) begin nerr++; $display("FAIL bp_accepted: got %0d want %0d", acc, 2*S); end
    nvec++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL bp_in_ready_full: got %b want 0", in_ready); end
    nvec++; if (int'(occupancy) !== 2*S) begin nerr++; $display("FAIL bp_occupancy_full: got %0d want %0d", occupancy, 2*S); end
    out_ready = 1; rose = 0; delivered = 0;
    for (int unsigned c = 0; c < 6*S; c++) begin
      #1 ov = out_valid; od = out_data;
      tick;
      if (ov) begin
        if (q.size() == 0) begin
          nvec++; nerr++; $display("FAIL bp_extra_beat: got %0h want none", od);
        end else begin
          exp_d = q.pop_front();
          delivered++;
          nvec++; if (od !== exp_d) begin nerr++; $display("FAIL bp_drain_data: got %0h want %0h", od, exp_d); end
        end
      end
      if (in_ready) rose = 1;
    end
    nvec++; if (delivered !== 2*S) begin nerr++; $display("FAIL bp_delivered: got %0d want %0d", delivered, 2*S); end
    nvec++; if (rose !== 1'b1) begin nerr++; $display("FAIL bp_in_ready_reopen: got %b want 1", rose); end
    nvec++; if (occupancy !== '0) begin nerr++; $display("FAIL bp_occupancy_empty: got %0d want 0", occupancy); end
  endtask

  task automatic test_random;
    int unsigned  sent, got, bad;
    logic         fi, fo;
    logic [W-1:0] od, di, exp_d;
    do_reset;
    sent = 0; got = 0; bad = 0;
    for (int unsigned c = 0; c < 20000 && got < 1000; c++) begin
      in_valid  = (sent < 1000) && ($urandom_range(1, 0) == 1);
      di        = $urandom;
      in_data   = di;
      out_ready = ($urandom_range(1, 0) == 1);
      #1 fi = in_valid & in_ready; fo = out_valid & out_ready; od = out_data;
      tick;
      if (fo) begin
        nvec++;
        if (q.size() == 0) begin
          nerr++; $display("FAIL rand_unexpected_beat: got %0h want none", od);
        end else begin
          exp_d = q.pop_front();
          got++;
          if (od !== exp_d) begin nerr++; $display("FAIL rand_data beat=%0d: got %0h want %0h", got, od, exp_d); end
        end
      end
      if (fi) begin q.push_back(di); sent++; end
      nvec++;
      if (int'(occupancy) !== q.size() || occupancy > OW'(2*S)) begin
        nerr++; bad++;
        if (bad < 10) $display("FAIL rand_occupancy: got %0d want %0d", occupancy, q.size());
      end
      nvec++; if (parity_err !== 1'b0) begin nerr++; $display("FAIL rand_parity_err: got %b want 0", parity_err); end
    end
    in_valid = 0; out_ready = 0;
    nvec++; if (got !== 1000) begin nerr++; $display("FAIL rand_timeout: got %0d beats want 1000", got); end
  endtask

  task automatic test_flush;
    logic [W-1:0] nxt, od;
    logic         f, ov;
    // Masked stages 0,1 only: the beats already in stages 2,3 survive.
    do_reset;
    m_out_ready = 0; nxt = 1;
    for (int unsigned c = 0; c < 20; c++) begin
      m_in_valid = (nxt <= 8);
      m_in_data  = nxt;
      #1 f = m_in_valid & m_in_ready;
      tick;
      if (f) nxt++;
    end
    m_in_valid = 0;
    nvec++; if (int'(m_occupancy) !== 8) begin nerr++; $display("FAIL flushm_full: got %0d want 8", m_occupancy); end
    m_flush = 1;
    #1;
    nvec++; if (m_out_valid !== 1'b1) begin nerr++; $display("FAIL flushm_out_valid_during: got %b want 1", m_out_valid); end
    tick;
    m_flush = 0;
    nvec++; if (int'(m_occupancy) !== 4) begin nerr++; $display("FAIL flushm_occupancy: got %0d want 4", m_occupancy); end
    nvec++; if (m_in_ready !== 1'b1) begin nerr++; $display("FAIL flushm_in_ready: got %b want 1", m_in_ready); end
    m_out_ready = 1; nxt = 1;
    for (int unsigned c = 0; c < 20; c++) begin
      #1 ov = m_out_valid; od = m_out_data;
      tick;
      if (ov) begin
        nvec++; if (od !== nxt) begin nerr++; $display("FAIL flushm_data: got %0h want %0h", od, nxt); end
        nxt++;
      end
    end
    nvec++; if (nxt !== 5) begin nerr++; $display("FAIL flushm_count: got %0d beats want 4", nxt - 1); end
    m_out_ready = 0;

    // Full mask: everything goes, and the output is masked in the flush cycle.
    out_ready = 0; nxt = 1;
    for (int unsigned c = 0; c < 20; c++) begin
      in_valid = (nxt <= 8);
      in_data  = nxt;
      #1 f = in_valid & in_ready;
      tick;
      if (f) nxt++;
    end
    in_valid = 0;
    flush = 1;
    #1;
    nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL flush_out_valid_during: got %b want 0", out_valid); end
    tick;
    flush = 0;
    nvec++; if (occupancy !== '0) begin nerr++; $display("FAIL flush_occupancy: got %0d want 0", occupancy); end
    nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL flush_in_ready: got %b want 1", in_ready); end
    nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL flush_out_valid_after: got %b want 0", out_valid); end
  endtask

  task automatic test_async_reset;
    logic exp_v;
    do_reset;
    out_ready = 1;
    for (int unsigned k = 0; k < S + 2; k++) begin
      in_valid = 1; in_data = W'(k + 1);
      tick;
    end
    nvec++; if (out_valid !== 1'b1) begin nerr++; $display("FAIL arst_pre_valid: got %b want 1", out_valid); end
    #2 rst_n = 0;
    #1;
    nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL arst_out_valid: got %b want 0", out_valid); end
    nvec++; if (occupancy !== '0) begin nerr++; $display("FAIL arst_occupancy: got %0d want 0", occupancy); end
    nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL arst_in_ready: got %b want 1", in_ready); end
    in_valid = 0;
    @(posedge clk);
    #1 rst_n = 1;
    for (int unsigned k = 0; k < S + 3; k++) begin
      in_valid = (k == 0); in_data = 32'hAA;
      tick;
      exp_v = (k == S - 1);
      nvec++; if (out_valid !== exp_v) begin nerr++; $display("FAIL arst_aa_valid k=%0d: got %b want %b", k, out_valid, exp_v); end
      if (exp_v) begin
        nvec++; if (out_data !== 32'hAA) begin nerr++; $display("FAIL arst_aa_data: got %0h want aa", out_data); end
      end
    end
    out_ready = 0;
  endtask

`ifdef PIPE_PARITY_EN
  // Corrupt the main entry of stage 2 (beat 3 when the chain is full).
  task automatic test_parity;
    logic [W-1:0] nxt, od, exp_d;
    logic         f, ov, exp_p;
    int unsigned  idx;
    do_reset;
    out_ready = 0; nxt = 1;
    for (int unsigned c = 0; c < 20; c++) begin
      in_valid = (nxt <= 8);
      in_data  = nxt;
      #1 f = in_valid & in_ready;
      tick;
      if (f) nxt++;
    end
    in_valid = 0;
    #1 dut.r_dm[2][0] = ~dut.r_dm[2][0];
    out_ready = 1; idx = 0;
    for (int unsigned c = 0; c < 20; c++) begin
      #1 ov = out_valid; od = out_data;
      tick;
      exp_p = ov && (idx == 2);
      nvec++; if (parity_err !== exp_p) begin nerr++; $display("FAIL parity_err idx=%0d: got %b want %b", idx, parity_err, exp_p); end
      if (ov) begin
        exp_d = W'(idx + 1);
        if (idx == 2) exp_d[0] = ~exp_d[0];
        nvec++; if (od !== exp_d) begin nerr++; $display("FAIL parity_data idx=%0d: got %0h want %0h", idx, od, exp_d); end
        idx++;
      end
    end
    out_ready = 0;
  endtask
`endif

  initial begin
    test_reset;
    test_stream;
    test_backpressure;
    test_random;
    test_flush;
    test_async_reset;
`ifdef PIPE_PARITY_EN
    test_parity;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
